// File: rtl/scanner.sv
// Data-collection scanner: captures a rolling sample value into a small FIFO at a fixed rate,
// then shifts the buffered bytes out MSB first on a registered dataOut/clkOut pair.
module scanner #(
  parameter int SAMPLE_PERIOD = 8,
  parameter int BUFFER_DEPTH  = 10,
  parameter int DATA_WIDTH    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       readyForTransferIn,
  input  logic [1:0] localTransferInput,
  output logic       clkOut,
  output logic       dataOut,
  output logic [3:0] dataBuffer
);

  localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [BIT_W-1:0] BIT_FIRST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [3:0]       PTR_LAST  = 4'(BUFFER_DEPTH - 1);
  localparam logic [3:0]       FULL      = 4'(BUFFER_DEPTH);

  localparam logic [1:0] CMD_COLLECT = 2'b01;
  localparam logic [1:0] CMD_FLUSH   = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    COLLECT  = 2'b01,
    STANDBY  = 2'b10,
    TRANSFER = 2'b11
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      sample_cnt, sample_cnt_nxt;
  logic [DATA_WIDTH-1:0] sample_val, sample_val_nxt;
  logic [3:0]            wptr, wptr_nxt;
  logic [3:0]            rptr, rptr_nxt;
  logic [3:0]            fill_nxt;
  logic [BIT_W-1:0]      bit_idx, bit_idx_nxt;
  logic                  phase, phase_nxt;
  logic                  wr_en;
  logic                  clk_out_nxt, data_out_nxt;
  logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];

  // State register together with counters, pointers and the registered serial outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sample_cnt <= '0;
      sample_val <= '0;
      wptr       <= 4'd0;
      rptr       <= 4'd0;
      dataBuffer <= 4'd0;
      bit_idx    <= '0;
      phase      <= 1'b0;
      clkOut     <= 1'b0;
      dataOut    <= 1'b0;
    end else begin
      state      <= state_nxt;
      sample_cnt <= sample_cnt_nxt;
      sample_val <= sample_val_nxt;
      wptr       <= wptr_nxt;
      rptr       <= rptr_nxt;
      dataBuffer <= fill_nxt;
      bit_idx    <= bit_idx_nxt;
      phase      <= phase_nxt;
      clkOut     <= clk_out_nxt;
      dataOut    <= data_out_nxt;
    end
  end

  // Sample storage; contents need no reset because the fill level gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= sample_val;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_nxt      = state;
    sample_cnt_nxt = sample_cnt;
    sample_val_nxt = sample_val;
    wptr_nxt       = wptr;
    rptr_nxt       = rptr;
    fill_nxt       = dataBuffer;
    bit_idx_nxt    = bit_idx;
    phase_nxt      = phase;
    wr_en          = 1'b0;
    case (state)
      IDLE: begin
        if (localTransferInput == CMD_COLLECT) begin
          state_nxt      = COLLECT;
          sample_cnt_nxt = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      COLLECT: begin
        if (sample_cnt == CNT_LAST) begin
          wr_en          = 1'b1;
          wptr_nxt       = (wptr == PTR_LAST) ? 4'd0 : wptr + 4'd1;
          sample_val_nxt = sample_val + 1'b1;
          fill_nxt       = dataBuffer + 4'd1;
          sample_cnt_nxt = '0;
          if (fill_nxt == FULL) begin
            state_nxt = STANDBY;
          end else begin
            state_nxt = COLLECT;
          end
        end else begin
          sample_cnt_nxt = sample_cnt + 1'b1;
        end
      end
      STANDBY: begin
        if (readyForTransferIn && (localTransferInput == CMD_FLUSH)) begin
          state_nxt   = TRANSFER;
          bit_idx_nxt = BIT_FIRST;
          phase_nxt   = 1'b0;
        end else begin
          state_nxt = STANDBY;
        end
      end
      TRANSFER: begin
        if (!phase) begin
          phase_nxt = 1'b1;
        end else begin
          phase_nxt = 1'b0;
          if (bit_idx == '0) begin
            rptr_nxt    = (rptr == PTR_LAST) ? 4'd0 : rptr + 4'd1;
            fill_nxt    = dataBuffer - 4'd1;
            bit_idx_nxt = BIT_FIRST;
            if (dataBuffer == 4'd1) begin
              state_nxt = IDLE;
            end else begin
              state_nxt = TRANSFER;
            end
          end else begin
            bit_idx_nxt = bit_idx - 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Serial outputs follow the upcoming state so clkOut/dataOut line up with the TRANSFER cycles.
  always_comb begin
    clk_out_nxt  = 1'b0;
    data_out_nxt = 1'b0;
    if (state_nxt == TRANSFER) begin
      clk_out_nxt  = phase_nxt;
      data_out_nxt = mem[rptr_nxt][bit_idx_nxt];
    end else begin
      clk_out_nxt  = 1'b0;
      data_out_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_scanner.sv
// Directed bench for scanner: fill-level timing, command gating, and a byte scoreboard
// rebuilt from the serial dataOut stream sampled on clkOut high.
module tb_scanner;
  logic       clk;
  logic       rst;
  logic       readyForTransferIn;
  logic [1:0] localTransferInput;
  logic       clkOut;
  logic       dataOut;
  logic [3:0] dataBuffer;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  localparam logic [31:0] S_IDLE     = 32'd0;
  localparam logic [31:0] S_COLLECT  = 32'd1;
  localparam logic [31:0] S_STANDBY  = 32'd2;
  localparam logic [31:0] S_TRANSFER = 32'd3;

  scanner dut (
    .clk                (clk),
    .rst                (rst),
    .readyForTransferIn (readyForTransferIn),
    .localTransferInput (localTransferInput),
    .clkOut             (clkOut),
    .dataOut            (dataOut),
    .dataBuffer         (dataBuffer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag, input logic [31:0] fill);
    chk({tag, "_state"}, 32'(dut.state), S_IDLE);
    chk({tag, "_fill"}, 32'(dataBuffer), fill);
    chk({tag, "_clkOut"}, 32'(clkOut), 32'd0);
    chk({tag, "_dataOut"}, 32'(dataOut), 32'd0);
  endtask

  // Walk ncyc TRANSFER cycles, rebuilding bytes and comparing against the queue.
  task automatic xfer(input int ncyc);
    logic [7:0] sh;
    logic       prev_d;
    logic [7:0] exp_b;
    sh     = 8'd0;
    prev_d = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      chk("clkOut_phase", 32'(clkOut), 32'(k % 2));
      if (k == 16) chk("fill_after_byte1", 32'(dataBuffer), 32'd9);
      if ((k % 2) == 1) begin
        chk("dataOut_hold", 32'(dataOut), 32'(prev_d));
        sh = {sh[6:0], dataOut};
        if ((k % 16) == 15) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL byte_queue: observed empty expected entry");
          end else begin
            exp_b = exp_q.pop_front();
            chk("byte", 32'(sh), 32'(exp_b));
          end
        end
      end else begin
        prev_d = dataOut;
      end
      step(1);
    end
  endtask

  initial begin
    rst                = 1'b1;
    readyForTransferIn = 1'b0;
    localTransferInput = 2'b00;
    step(2);
    rst = 1'b0;
    step(4);
    chk_idle_outputs("reset", 32'd0);

    // First collection run, with an early flush attempt that must be ignored.
    localTransferInput = 2'b01;
    step(1);
    localTransferInput = 2'b00;
    chk("collect_entry", 32'(dut.state), S_COLLECT);
    step(8);
    chk("fill_8clk", 32'(dataBuffer), 32'd1);
    step(24);
    chk("fill_32clk", 32'(dataBuffer), 32'd4);
    readyForTransferIn = 1'b1;
    localTransferInput = 2'b10;
    step(8);
    chk("fill_40clk", 32'(dataBuffer), 32'd5);
    chk("early_flush_ignored", 32'(dut.state), S_COLLECT);
    readyForTransferIn = 1'b0;
    localTransferInput = 2'b00;
    step(40);
    chk("fill_80clk", 32'(dataBuffer), 32'd10);
    chk("standby_entry", 32'(dut.state), S_STANDBY);
    step(20);
    chk("standby_hold_fill", 32'(dataBuffer), 32'd10);
    chk("standby_hold_state", 32'(dut.state), S_STANDBY);

    // Flush without ready must not start a transfer.
    localTransferInput = 2'b10;
    step(10);
    chk("no_ready_state", 32'(dut.state), S_STANDBY);
    chk("no_ready_clkOut", 32'(clkOut), 32'd0);

    // Full flush: bytes 0x00..0x09, oldest first.
    readyForTransferIn = 1'b1;
    step(1);
    readyForTransferIn = 1'b0;
    localTransferInput = 2'b00;
    chk("transfer_entry", 32'(dut.state), S_TRANSFER);
    for (int i = 0; i < 10; i++) exp_q.push_back(8'(i));
    xfer(160);
    chk_idle_outputs("flush_done", 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    // Second run continues the sample sequence; reset aborts it at fill 7.
    localTransferInput = 2'b01;
    step(1);
    localTransferInput = 2'b00;
    step(80);
    chk("run2_full", 32'(dataBuffer), 32'd10);
    readyForTransferIn = 1'b1;
    localTransferInput = 2'b10;
    step(1);
    readyForTransferIn = 1'b0;
    localTransferInput = 2'b00;
    for (int i = 0; i < 3; i++) exp_q.push_back(8'(8'h0A + i));
    xfer(48);
    chk("run2_fill_before_rst", 32'(dataBuffer), 32'd7);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk_idle_outputs("mid_rst", 32'd0);
    exp_q.delete();

    // Restart after reset: empty buffer, sample value back to zero.
    localTransferInput = 2'b01;
    step(1);
    localTransferInput = 2'b00;
    chk("run3_fill_start", 32'(dataBuffer), 32'd0);
    step(8);
    chk("run3_fill_8clk", 32'(dataBuffer), 32'd1);
    step(72);
    chk("run3_full", 32'(dataBuffer), 32'd10);
    readyForTransferIn = 1'b1;
    localTransferInput = 2'b10;
    step(1);
    readyForTransferIn = 1'b0;
    localTransferInput = 2'b00;
    exp_q.push_back(8'h00);
    xfer(17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
